// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers 14-bit words from a host in a small FIFO and
// issues them one at a time to proc, waiting on Done and flagging a hung proc.
module instr_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 7
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [13:0]            InWord,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic                   Enable,
    input  logic                   Done,
    output logic                   w,
    output logic [1:0]             F,
    output logic [1:0]             Rx,
    output logic [1:0]             Ry,
    output logic [7:0]             Data,
    output logic                   Busy,
    output logic                   Error,
    output logic [7:0]             Retired,
    output logic [$clog2(DEPTH):0] Level
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
    localparam logic [TW-1:0] TCNT_ZERO = TW'(0);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    logic [13:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tcnt;
    logic          r_w;
    logic [1:0]    r_f;
    logic [1:0]    r_rx;
    logic [1:0]    r_ry;
    logic [7:0]    r_data;
    logic          r_error;
    logic [7:0]    r_retired;

    logic          w_full;
    logic          w_nonempty;
    logic          w_push;
    logic          w_issue;
    logic          w_retire;
    logic          w_tcnt_clr;
    logic          w_tcnt_inc;
    logic          w_set_error;
    logic [13:0]   w_head;

    assign w_full     = (r_count == CNT_FULL);
    assign w_nonempty = (r_count != CNT_ZERO);
    // A full FIFO refuses the host even if a pop happens in the same cycle.
    assign w_push     = InValid & ~w_full;
    assign w_head     = r_mem[r_rd_ptr];

    // FIFO storage; contents are don't-care until the pointers say otherwise
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= InWord;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_retire    = 1'b0;
        w_tcnt_clr  = 1'b0;
        w_tcnt_inc  = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty && Enable) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_tcnt_clr  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (Done) begin
                    w_retire = 1'b1;
                    // Back-to-back issue lands the next w on proc's T0.
                    if (w_nonempty && Enable) begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tcnt_inc = 1'b1;
                    if (r_tcnt == TCNT_LAST) begin
                        w_set_error = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // WAIT-cycle counter for the Done timeout
    always_ff @(posedge Clock) begin
        if (Reset || w_tcnt_clr) begin
            r_tcnt <= TCNT_ZERO;
        end else if (w_tcnt_inc) begin
            r_tcnt <= r_tcnt + TCNT_ONE;
        end
    end

    // proc command outputs; fields stay put until the next issue
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_w    <= 1'b0;
            r_f    <= 2'b00;
            r_rx   <= 2'b00;
            r_ry   <= 2'b00;
            r_data <= 8'h00;
        end else begin
            r_w <= w_issue;
            if (w_issue) begin
                r_f    <= w_head[13:12];
                r_rx   <= w_head[11:10];
                r_ry   <= w_head[9:8];
                r_data <= w_head[7:0];
            end
        end
    end

    // Sticky timeout flag and retirement counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_error   <= 1'b0;
            r_retired <= 8'd0;
        end else begin
            if (w_set_error) begin
                r_error <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    assign InReady = ~w_full;
    assign w       = r_w;
    assign F       = r_f;
    assign Rx      = r_rx;
    assign Ry      = r_ry;
    assign Data    = r_data;
    assign Busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign Error   = r_error;
    assign Retired = r_retired;
    assign Level   = r_count;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a proc model answers w with Done, a reference model
// predicts every observable each cycle, and a scoreboard checks the issued words.
module tb_instr_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 7;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [13:0] InWord;
    logic        InValid;
    logic        InReady;
    logic        Enable;
    logic        Done;
    logic        w;
    logic [1:0]  F, Rx, Ry;
    logic [7:0]  Data;
    logic        Busy;
    logic        Error;
    logic [7:0]  Retired;
    logic [3:0]  Level;

    instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .InWord(InWord), .InValid(InValid),
        .InReady(InReady), .Enable(Enable), .Done(Done), .w(w), .F(F),
        .Rx(Rx), .Ry(Ry), .Data(Data), .Busy(Busy), .Error(Error),
        .Retired(Retired), .Level(Level)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- proc model: Done 1 cycle after w for mvi/mv, 3 for add/sub
    logic       done_m = 1'b0;
    logic       done_force = 1'b0;
    logic       hang = 1'b0;
    int         cd = 0;
    logic [7:0] pr [4];
    logic       rs;
    assign Done = (done_m & ~hang) | done_force;

    always @(posedge Clock) begin
        rs = Reset;
        #1;
        if (rs) begin
            cd = 0;
            done_m = 1'b0;
            for (int i = 0; i < 4; i++) pr[i] = 8'h00;
        end else if (w === 1'b1) begin
            cd = F[1] ? 3 : 1;
            done_m = 1'b0;
            case (F)
                2'b00:   pr[Rx] = Data;
                2'b01:   pr[Rx] = pr[Ry];
                2'b10:   pr[Rx] = pr[Rx] + pr[Ry];
                default: pr[Rx] = pr[Rx] - pr[Ry];
            endcase
        end else if (cd > 0) begin
            cd--;
            done_m = (cd == 0);
        end else begin
            done_m = 1'b0;
        end
    end

    // ---------------- reference model (phase: 0 idle, 1 issuing, 2 waiting, 3 halted)
    int          ph = 0, m_level = 0, m_tcnt = 0, m_ret = 0, m_acc = 0;
    bit          m_err = 0, m_w = 0, m_rst = 0, do_push, do_pop;
    logic [13:0] sb [$];

    always @(posedge Clock) begin
        if (Reset) begin
            ph = 0; m_level = 0; m_tcnt = 0; m_ret = 0;
            m_err = 0; m_w = 0; m_rst = 1;
            sb.delete();
        end else begin
            m_rst   = 0;
            do_push = InValid && (m_level < DEPTH);
            do_pop  = 0;
            m_w     = 0;
            case (ph)
                0: if (m_level > 0 && Enable) begin do_pop = 1; ph = 1; m_w = 1; end
                1: begin m_tcnt = 0; ph = 2; end
                2: begin
                    if (Done === 1'b1) begin
                        m_ret = (m_ret + 1) % 256;
                        ph = 0;
                        if (m_level > 0 && Enable) begin do_pop = 1; ph = 1; m_w = 1; end
                    end else begin
                        m_tcnt++;
                        if (m_tcnt == TIMEOUT) begin m_err = 1; ph = 3; end
                    end
                end
                default: ;
            endcase
            if (do_push) begin
                sb.push_back(InWord);
                m_acc++;
            end
            m_level = m_level + int'(do_push) - int'(do_pop);
        end
    end

    // ---------------- monitor: per-cycle observables and scoreboard of issued words
    int          n_issue = 0;
    longint      issue_t [$];
    logic [13:0] last_exp;
    bit          have_last = 0;

    always @(negedge Clock) begin
        check("w", w, m_w);
        check("level", Level, m_level);
        check("inready", InReady, m_level < DEPTH);
        check("busy", Busy, (ph == 1 || ph == 2));
        check("error", Error, m_err);
        check("retired", Retired, m_ret);
        if (m_rst) begin
            check("rst_fields", {F, Rx, Ry, Data}, 14'h0000);
            have_last = 0;
        end
        if (w === 1'b1) begin
            n_issue++;
            issue_t.push_back($time);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_word: got %0h expected none (queue empty) at %0t",
                         {F, Rx, Ry, Data}, $time);
            end else begin
                last_exp  = sb.pop_front();
                have_last = 1;
                check("issue_word", {F, Rx, Ry, Data}, last_exp);
            end
        end else if (ph == 2 && have_last) begin
            check("hold_word", {F, Rx, Ry, Data}, last_exp);
        end
    end

    // ---------------- stimulus
    longint push_t;

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic push(input logic [13:0] wd);
        InValid = 1'b1;
        InWord  = wd;
        push_t  = $time;
        tick();
        InValid = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int b = 0;
        while (!(ph == 0 && m_level == 0) && b < 400) begin
            tick();
            b++;
        end
        check({tag, "_drain_bound"}, b < 400, 1'b1);
    endtask

    function automatic logic [13:0] mk(input logic [1:0] f, input logic [1:0] rx,
                                       input logic [1:0] ry, input logic [7:0] d);
        return {f, rx, ry, d};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int     b, n0, a0;
        longint t_w, t_err;
        Reset = 1'b1; InValid = 1'b0; InWord = 14'h0000; Enable = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("reset_ready", InReady, 1'b1);

        // 1: single mvi R0,#0x5A
        Enable = 1'b1;
        issue_t.delete();
        push(mk(2'b00, 2'b00, 2'b00, 8'h5A));
        drain("t1");
        check("t1_issues", issue_t.size(), 1);
        if (issue_t.size() > 0) check("t1_latency", 32'(issue_t[0] - push_t), 20);
        check("t1_retired", Retired, 8'd1);
        check("t1_level", Level, 4'd0);

        // 2: mvi R1,#3; mvi R2,#4; add R1,R2; sub R1,R2
        do_reset();
        issue_t.delete();
        push(mk(2'b00, 2'b01, 2'b00, 8'd3));
        push(mk(2'b00, 2'b10, 2'b00, 8'd4));
        push(mk(2'b10, 2'b01, 2'b10, 8'd0));
        push(mk(2'b11, 2'b01, 2'b10, 8'd0));
        drain("t2");
        check("t2_issues", issue_t.size(), 4);
        if (issue_t.size() == 4) begin
            check("t2_gap1", 32'(issue_t[1] - issue_t[0]), 20);
            check("t2_gap2", 32'(issue_t[2] - issue_t[1]), 20);
            check("t2_gap3", 32'(issue_t[3] - issue_t[2]), 40);
        end
        check("t2_retired", Retired, 8'd4);
        check("t2_r1", pr[1], 8'd3);

        // 3: overfill with Enable low, then release
        do_reset();
        Enable = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(14'($urandom));
        check("t3_level_full", Level, 4'd8);
        check("t3_ready_full", InReady, 1'b0);
        n0 = n_issue;
        Enable = 1'b1;
        drain("t3");
        check("t3_issues", n_issue - n0, 8);
        check("t3_retired", Retired, 8'd8);

        // 4: Done never arrives
        do_reset();
        hang = 1'b1;
        issue_t.delete();
        push(mk(2'b10, 2'b00, 2'b01, 8'd0));
        b = 0;
        while (Error !== 1'b1 && b < 40) begin tick(); b++; end
        check("t4_error_bound", b < 40, 1'b1);
        t_err = $time;
        t_w = (issue_t.size() > 0) ? issue_t[0] : 0;
        // TIMEOUT full WAIT cycles without Done, then Error on the following edge
        check("t4_error_delay", 32'(t_err - t_w), (TIMEOUT + 1) * 10);
        check("t4_busy_halt", Busy, 1'b0);
        n0 = n_issue;
        push(14'($urandom));
        push(14'($urandom));
        for (int i = 0; i < 20; i++) tick();
        check("t4_level_halt", Level, 4'd2);
        check("t4_no_issue", n_issue - n0, 0);
        hang = 1'b0;
        do_reset();
        check("t4_error_clr", Error, 1'b0);
        check("t4_level_clr", Level, 4'd0);

        // 5: Reset during WAIT with 3 words queued
        push(mk(2'b00, 2'b00, 2'b00, 8'h11));
        push(mk(2'b00, 2'b01, 2'b00, 8'h22));
        drain("t5a");
        check("t5_retired_pre", Retired, 8'd2);
        push(mk(2'b10, 2'b00, 2'b01, 8'd0));
        for (int i = 0; i < 3; i++) push(mk(2'b00, 2'(i), 2'b00, 8'(i)));
        check("t5_level_pre", Level, 4'd3);
        check("t5_busy_pre", Busy, 1'b1);
        do_reset();
        check("t5_w", w, 1'b0);
        check("t5_level", Level, 4'd0);
        check("t5_busy", Busy, 1'b0);
        check("t5_retired", Retired, 8'd0);
        Enable = 1'b0;
        done_force = 1'b1;
        tick();
        done_force = 1'b0;
        tick();
        check("t5_retired_post", Retired, 8'd0);

        // 6: 256 mvi words with refill; Retired wraps
        do_reset();
        Enable = 1'b1;
        a0 = m_acc;
        n0 = n_issue;
        b = 0;
        while (m_acc - a0 < 256 && b < 4000) begin
            InValid = ($urandom_range(0, 9) < 7);
            InWord  = {2'b00, 4'($urandom), 8'($urandom)};
            tick();
            b++;
        end
        InValid = 1'b0;
        check("t6_push_bound", b < 4000, 1'b1);
        drain("t6");
        check("t6_issues", n_issue - n0, 256);
        check("t6_retired_wrap", Retired, 8'd0);

        // 7: random words, random Enable and InValid
        do_reset();
        for (int i = 0; i < 300; i++) begin
            InValid = ($urandom_range(0, 1) == 1);
            InWord  = 14'($urandom);
            Enable  = ($urandom_range(0, 4) != 0);
            tick();
        end
        InValid = 1'b0;
        Enable  = 1'b1;
        drain("t7");
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
